// File: rtl/btn_event_ctrl.sv
// Multi-button debouncer: shared tick prescaler, per-button press/release/long
// classification, round-robin arbitration onto one valid/ready event channel.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int DIV_CNT      = 18,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 64,
  localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_code,
  output logic [N_BTN-1:0] overrun,
  input  logic [N_BTN-1:0] clr_overrun
);

  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_TICKS);

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_PRESS = 2'b01;
  localparam logic [1:0] C_REL   = 2'b10;
  localparam logic [1:0] C_LONG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } st_t;

  logic [N_BTN-1:0]   s1;
  logic [N_BTN-1:0]   s;
  logic [DIV_CNT-1:0] pcnt;
  logic               tick;

  st_t             st_q   [N_BTN];
  st_t             st_d   [N_BTN];
  logic [SW-1:0]   scnt_q [N_BTN];
  logic [SW-1:0]   scnt_d [N_BTN];
  logic [LW-1:0]   lcnt_q [N_BTN];
  logic [LW-1:0]   lcnt_d [N_BTN];
  logic [N_BTN-1:0] ldone_q;
  logic [N_BTN-1:0] ldone_d;

  logic [N_BTN-1:0] post;
  logic [1:0]       post_code [N_BTN];
  logic [1:0]       slot_q    [N_BTN];

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant;
  logic [1:0]       grant_code;
  logic             found;
  logic             adv;
  logic             load;
  logic [N_BTN-1:0] drain;

  // Two-FF synchronizer; only s feeds the FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= btn;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= '0;
    else        pcnt <= pcnt + 1'b1;
  end

  assign tick = &pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]   <= IDLE;
        scnt_q[i] <= '0;
        lcnt_q[i] <= '0;
      end
      ldone_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i]   <= st_d[i];
        scnt_q[i] <= scnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
      ldone_q <= ldone_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]      = st_q[i];
      scnt_d[i]    = scnt_q[i];
      lcnt_d[i]    = lcnt_q[i];
      ldone_d[i]   = ldone_q[i];
      post[i]      = 1'b0;
      post_code[i] = C_NONE;
      unique case (st_q[i])
        IDLE: begin
          if (s[i]) begin
            st_d[i]   = PRESS_CHK;
            scnt_d[i] = '0;
          end
        end
        PRESS_CHK: begin
          if (!s[i]) begin
            st_d[i] = IDLE;
          end else if (tick) begin
            scnt_d[i] = scnt_q[i] + 1'b1;
            if (scnt_q[i] == S_LAST) begin
              st_d[i]      = HELD;
              lcnt_d[i]    = '0;
              ldone_d[i]   = 1'b0;
              post[i]      = 1'b1;
              post_code[i] = C_PRESS;
            end
          end
        end
        HELD: begin
          if (!s[i]) begin
            st_d[i]   = REL_CHK;
            scnt_d[i] = '0;
          end else if (tick && lcnt_q[i] < L_MAX) begin
            lcnt_d[i] = lcnt_q[i] + 1'b1;
            // long_done survives REL_CHK bounces: one LONG per press.
            if (lcnt_q[i] == L_LAST && !ldone_q[i]) begin
              ldone_d[i]   = 1'b1;
              post[i]      = 1'b1;
              post_code[i] = C_LONG;
            end
          end
        end
        REL_CHK: begin
          if (s[i]) begin
            st_d[i] = HELD;
          end else if (tick) begin
            scnt_d[i] = scnt_q[i] + 1'b1;
            if (scnt_q[i] == S_LAST) begin
              st_d[i]      = IDLE;
              post[i]      = 1'b1;
              post_code[i] = C_REL;
            end
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      level[i] = (st_q[i] == HELD) || (st_q[i] == REL_CHK);
    end
  end

  // ptr_q is the first index searched, i.e. last grant + 1.
  always_comb begin
    int best;
    int d;
    best       = N_BTN;
    d          = 0;
    found      = 1'b0;
    grant      = '0;
    grant_code = C_NONE;
    for (int i = 0; i < N_BTN; i++) begin
      d = (i - int'(ptr_q) + N_BTN) % N_BTN;
      if (slot_q[i] != C_NONE && d < best) begin
        best       = d;
        found      = 1'b1;
        grant      = IDW'(i);
        grant_code = slot_q[i];
      end
    end
  end

  assign adv  = !evt_valid || evt_ready;
  assign load = adv && found;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      drain[i] = load && (grant == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) slot_q[i] <= C_NONE;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (post[i] && (slot_q[i] == C_NONE || drain[i])) begin
          slot_q[i] <= post_code[i];
        end else if (drain[i]) begin
          slot_q[i] <= C_NONE;
        end
        if (post[i] && slot_q[i] != C_NONE && !drain[i]) begin
          overrun[i] <= 1'b1;
        end else if (clr_overrun[i]) begin
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_code  <= C_NONE;
      ptr_q     <= '0;
    end else if (adv) begin
      evt_valid <= found;
      if (found) begin
        evt_id   <= grant;
        evt_code <= grant_code;
        if (grant == IDW'(N_BTN - 1)) ptr_q <= '0;
        else                          ptr_q <= grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a short prescaler
// (N_BTN=4, DIV_CNT=2, STABLE_TICKS=3, LONG_TICKS=5).
module tb_btn_event_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_code;
  logic [3:0] overrun;
  logic [3:0] clr_overrun;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    int id;
    int code;
    int t;
  } ev_t;
  ev_t q[$];

  btn_event_ctrl #(
    .N_BTN(4),
    .DIV_CNT(2),
    .STABLE_TICKS(3),
    .LONG_TICKS(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .level(level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_code(evt_code),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake as seen half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready)
      q.push_back('{int'(evt_id), int'(evt_code), cyc});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = '0;
    clr_overrun = '0;
    evt_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    tests++;
    if (level !== 4'h0) begin
      fails++;
      $display("FAIL reset_level: got %h want 0", level);
    end
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", evt_valid);
    end
    tests++;
    if (evt_id !== 2'd0 || evt_code !== 2'd0) begin
      fails++;
      $display("FAIL reset_evt: got id=%0d code=%0d want 0/0",
               evt_id, evt_code);
    end
    tests++;
    if (overrun !== 4'h0) begin
      fails++;
      $display("FAIL reset_overrun: got %h want 0", overrun);
    end
  endtask

  task automatic test_press_release();
    int rise;
    rise = 0;
    q.delete();
    btn[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (rise == 0 && level[0]) rise = k;
    end
    tests++;
    if (rise < 12 || rise > 15) begin
      fails++;
      $display("FAIL pr_level_rise: got %0d cycles want 12..15", rise);
    end
    btn[0] = 1'b0;
    step(40);
    tests++;
    if (q.size() !== 2) begin
      fails++;
      $display("FAIL pr_count: got %0d events want 2", q.size());
    end else begin
      tests++;
      if (q[0].id != 0 || q[0].code != 1) begin
        fails++;
        $display("FAIL pr_press: got id=%0d code=%0d want 0/1",
                 q[0].id, q[0].code);
      end
      tests++;
      if (q[1].id != 0 || q[1].code != 2) begin
        fails++;
        $display("FAIL pr_release: got id=%0d code=%0d want 0/2",
                 q[1].id, q[1].code);
      end
    end
    tests++;
    if (level !== 4'h0 || overrun !== 4'h0) begin
      fails++;
      $display("FAIL pr_final: got level=%h ovr=%h want 0/0",
               level, overrun);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    q.delete();
    repeat (3) begin
      btn[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        step(1);
        if (level[1]) bad++;
      end
      btn[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step(1);
        if (level[1]) bad++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (level[1]) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch_level: got %0d high cycles want 0", bad);
    end
    tests++;
    if (q.size() !== 0) begin
      fails++;
      $display("FAIL glitch_events: got %0d events want 0", q.size());
    end
  endtask

  task automatic test_long();
    q.delete();
    btn[2] = 1'b1;
    step(46);
    btn[2] = 1'b0;
    step(3);
    btn[2] = 1'b1;
    step(14);
    tests++;
    if (level[2] !== 1'b1) begin
      fails++;
      $display("FAIL long_glitch_level: got %b want 1", level[2]);
    end
    btn[2] = 1'b0;
    step(40);
    tests++;
    if (q.size() !== 3) begin
      fails++;
      $display("FAIL long_count: got %0d events want 3", q.size());
    end else begin
      tests++;
      if (q[0].id != 2 || q[0].code != 1 || q[1].id != 2 ||
          q[1].code != 3 || q[2].id != 2 || q[2].code != 2) begin
        fails++;
        $display("FAIL long_seq: got codes %0d,%0d,%0d want 1,3,2",
                 q[0].code, q[1].code, q[2].code);
      end
      tests++;
      if (q[1].t - q[0].t != 20) begin
        fails++;
        $display("FAIL long_delay: got %0d cycles want 20",
                 q[1].t - q[0].t);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    bit stable;
    int id0;
    int code0;
    seen = 0;
    stable = 1;
    id0 = -1;
    code0 = -1;
    do_reset();
    evt_ready = 1'b0;
    btn = 4'hF;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (evt_valid) begin
        if (!seen) begin
          seen = 1;
          id0 = int'(evt_id);
          code0 = int'(evt_code);
        end else if (int'(evt_id) != id0 || int'(evt_code) != code0) begin
          stable = 0;
        end
      end else if (seen) begin
        stable = 0;
      end
    end
    tests++;
    if (!seen || id0 != 0 || code0 != 1) begin
      fails++;
      $display("FAIL b2b_first: got seen=%0d id=%0d code=%0d want 1/0/1",
               seen, id0, code0);
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL b2b_hold: got unstable output want stable");
    end
    evt_ready = 1'b1;
    step(6);
    tests++;
    if (q.size() < 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d events want >=4", q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (q[k].id != k || q[k].code != 1 || q[k].t != q[0].t + k) begin
          fails++;
          $display("FAIL b2b_ev%0d: got id=%0d code=%0d dt=%0d want %0d/1/%0d",
                   k, q[k].id, q[k].code, q[k].t - q[0].t, k, k);
        end
      end
    end
    btn = 4'h0;
    step(50);
  endtask

  task automatic test_overrun();
    bit seen;
    bit fell;
    bit rose;
    seen = 0;
    fell = 0;
    rose = 0;
    do_reset();
    evt_ready = 1'b0;
    btn[3] = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1);
      if (evt_valid) seen = 1;
    end
    tests++;
    if (!seen || evt_id !== 2'd3 || evt_code !== 2'b01) begin
      fails++;
      $display("FAIL ovr_press: got v=%0d id=%0d code=%0d want 1/3/1",
               seen, evt_id, evt_code);
    end
    btn[3] = 1'b0;
    for (int k = 0; k < 40 && !fell; k++) begin
      step(1);
      if (!level[3]) fell = 1;
    end
    step(3);
    tests++;
    if (!fell || evt_id !== 2'd3 || evt_code !== 2'b01 || overrun !== 4'h0) begin
      fails++;
      $display("FAIL ovr_held: got fell=%0d id=%0d code=%0d ovr=%h want 1/3/1/0",
               fell, evt_id, evt_code, overrun);
    end
    btn[3] = 1'b1;
    for (int k = 0; k < 40 && !rose; k++) begin
      step(1);
      if (level[3]) rose = 1;
    end
    step(2);
    tests++;
    if (!rose || overrun !== 4'b1000) begin
      fails++;
      $display("FAIL ovr_set: got rose=%0d ovr=%h want 1/8", rose, overrun);
    end
    clr_overrun[3] = 1'b1;
    step(1);
    clr_overrun[3] = 1'b0;
    tests++;
    if (overrun !== 4'h0) begin
      fails++;
      $display("FAIL ovr_clear: got %h want 0", overrun);
    end
    evt_ready = 1'b1;
    step(4);
    tests++;
    if (q.size() !== 2) begin
      fails++;
      $display("FAIL ovr_drain_count: got %0d want 2", q.size());
    end else begin
      tests++;
      if (q[0].id != 3 || q[0].code != 1 || q[1].id != 3 || q[1].code != 2) begin
        fails++;
        $display("FAIL ovr_drain: got %0d/%0d,%0d/%0d want 3/1,3/2",
                 q[0].id, q[0].code, q[1].id, q[1].code);
      end
    end
    btn[3] = 1'b0;
    step(40);
  endtask

  task automatic test_async_reset();
    bit seen;
    int rise;
    seen = 0;
    rise = 0;
    do_reset();
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1);
      if (evt_valid) seen = 1;
    end
    tests++;
    if (!seen || level[0] !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre: got valid=%0d level=%b want 1/1", seen, level[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (evt_valid !== 1'b0 || level !== 4'h0 ||
        evt_id !== 2'd0 || evt_code !== 2'd0) begin
      fails++;
      $display("FAIL ar_async: got v=%b lvl=%h id=%0d code=%0d want 0",
               evt_valid, level, evt_id, evt_code);
    end
    step(2);
    q.delete();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int k = 1; k <= 30 && rise == 0; k++) begin
      step(1);
      if (level[0]) rise = k;
    end
    tests++;
    if (rise != 12) begin
      fails++;
      $display("FAIL ar_redetect: got %0d cycles want 12", rise);
    end
    step(4);
    tests++;
    if (q.size() !== 1) begin
      fails++;
      $display("FAIL ar_events: got %0d events want 1", q.size());
    end else begin
      tests++;
      if (q[0].id != 0 || q[0].code != 1) begin
        fails++;
        $display("FAIL ar_event: got id=%0d code=%0d want 0/1",
                 q[0].id, q[0].code);
      end
    end
    btn = 4'h0;
    step(40);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    btn = '0;
    evt_ready = 1'b1;
    clr_overrun = '0;
    do_reset();
    test_reset();
    test_press_release();
    test_glitch();
    test_long();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
